// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, branch redirect and mult/div busy-window sequencing for the 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       id_md_start,
  input  logic       id_md_read,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       md_start,
  output logic       md_busy
);
  typedef enum logic {RUN, MD_BUSY} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic load_use, md_hold, stall, start_ok;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    load_use = ex_mem_read && ex_rt != 5'd0 &&
               ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
    md_hold = state == MD_BUSY && (id_md_read || id_md_start);
    stall = !ex_branch_taken && (md_hold || load_use);
    start_ok = id_md_start && state == RUN && !ex_branch_taken && !load_use;
    // a taken branch never aborts an issued op, so the count runs regardless
    state_nxt = state == RUN ? (start_ok ? MD_BUSY : RUN) : (cnt == '0 ? RUN : MD_BUSY);
    cnt_nxt = state == RUN ? (start_ok ? CNT_W'(MD_LATENCY - 1) : cnt) : (cnt == '0 ? '0 : cnt - 1'b1);
    pc_en = !rst && !stall;
    if_id_en = !rst && !stall;
    if_id_flush = rst || ex_branch_taken;
    id_ex_flush = rst || ex_branch_taken || stall;
    md_start = !rst && start_ok;
    md_busy = !rst && state == MD_BUSY;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench comparing outputs against a busy-countdown reference model
module tb_pipe_hazard_ctrl;
  localparam int LAT = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_use_rs = 0, id_use_rt = 0, ex_mem_read = 0, ex_branch_taken = 0, id_md_start = 0, id_md_read = 0;
  logic pc_en, if_id_en, if_id_flush, id_ex_flush, md_start, md_busy;
  logic [5:0] exp_q[$];
  logic [5:0] obs;
  int n_chk = 0, n_fail = 0, busy_left = 0, stalls = 0, busys = 0;

  pipe_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .id_md_start(id_md_start), .id_md_read(id_md_read), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .md_start(md_start), .md_busy(md_busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model();
    logic lu, busy;
    lu = ex_mem_read && ex_rt != 0 && ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
    busy = busy_left > 0;
    if (rst) return 6'b001100;
    if (ex_branch_taken) return {5'b11110, busy};
    if (lu || (busy && (id_md_read || id_md_start))) return {5'b00010, busy};
    return {4'b1100, id_md_start, busy};
  endfunction

  // one cycle: settle, push expectation, compare, then advance the model at the edge
  task automatic cyc(input string tag);
    logic [5:0] e;
    #1;
    if (rst) busy_left = 0;
    exp_q.push_back(model());
    obs = {pc_en, if_id_en, if_id_flush, id_ex_flush, md_start, md_busy};
    e = exp_q.pop_front();
    check(tag, {26'd0, obs}, {26'd0, e});
    if (!obs[5]) stalls++;
    if (obs[0]) busys++;
    @(posedge clk);
    if (rst) busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (e[1]) busy_left = LAT;
    #1;
  endtask

  task automatic idle();
    {id_rs, id_rt, ex_rt} = '0;
    {id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken, id_md_start, id_md_read} = '0;
  endtask

  initial begin
    @(posedge clk); #1;
    cyc("reset");
    check("reset_vec", {26'd0, obs}, 32'h0c);
    rst = 0;
    cyc("idle");
    ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_use_rs = 1;
    cyc("lu_stall");
    check("lu_pc_en", {31'd0, obs[5]}, 0);
    ex_mem_read = 0;
    cyc("lu_after");
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    cyc("lu_r0");
    check("lu_r0_pc_en", {31'd0, obs[5]}, 1);
    id_use_rs = 0; id_use_rt = 1; id_rt = 9; ex_rt = 9;
    cyc("lu_rt");
    idle();
    id_md_start = 1;
    cyc("md_start");
    check("md_start_pulse", {31'd0, obs[1]}, 1);
    id_md_start = 0; id_md_read = 1; stalls = 0; busys = 0;
    for (int i = 0; i < LAT; i++) cyc("mflo_hold");
    check("mflo_stalls", stalls, LAT);
    check("mflo_busys", busys, LAT);
    cyc("mflo_go");
    check("mflo_adv", {31'd0, obs[5]}, 1);
    check("mflo_busy_off", {31'd0, obs[0]}, 0);
    idle();
    id_md_start = 1;
    cyc("md_start2");
    id_md_start = 0; id_md_read = 1; ex_branch_taken = 1; busys = 0;
    cyc("br_prio");
    check("br_prio_vec", {26'd0, obs}, 32'h3d);
    ex_branch_taken = 0;
    for (int i = 0; i < LAT - 1; i++) cyc("post_br");
    cyc("post_br_go");
    check("br_cnt_runs", busys, LAT);
    idle();
    id_md_start = 1; ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_use_rs = 1;
    cyc("start_lu");
    check("start_lu_md", {31'd0, obs[1]}, 0);
    ex_mem_read = 0;
    cyc("start_after_lu");
    check("start_after_md", {31'd0, obs[1]}, 1);
    idle();
    for (int i = 0; i < LAT; i++) cyc("drain");
    id_md_start = 1; ex_branch_taken = 1;
    cyc("start_br");
    check("start_br_md", {31'd0, obs[1]}, 0);
    idle();
    cyc("still_run");
    check("still_run_busy", {31'd0, obs[0]}, 0);
    id_md_start = 1;
    cyc("b2b_first");
    stalls = 0;
    for (int i = 0; i < LAT; i++) cyc("b2b_hold");
    check("b2b_stalls", stalls, LAT);
    cyc("b2b_second");
    check("b2b_start", {31'd0, obs[1]}, 1);
    id_md_start = 0; busys = 0;
    for (int i = 0; i < LAT + 1; i++) cyc("b2b_busy");
    check("b2b_busys", busys, LAT);
    id_md_start = 1;
    cyc("rst_pre");
    id_md_start = 0;
    cyc("rst_mid_busy");
    #2 rst = 1;
    #1 check("rst_async", {26'd0, pc_en, if_id_en, if_id_flush, id_ex_flush, md_start, md_busy}, 32'h0c);
    cyc("rst_mid");
    rst = 0;
    cyc("rst_rel");
    check("rst_rel_vec", {26'd0, obs}, 32'h30);
    for (int i = 0; i < 300; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_branch_taken = $urandom_range(0, 7) == 0; id_md_start = $urandom_range(0, 5) == 0;
      id_md_read = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 63) == 0;
      cyc("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
